// File: rtl/aes_block_ctrl_if.sv
// Buffer, AES core and UART transmitter signals seen by the block sequencer.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface aes_block_ctrl_if;
   logic         buf_empty;
   logic [127:0] buf_dout;
   logic         buf_read_en;
   logic [127:0] aes_din;
   logic         aes_start;
   logic         aes_done;
   logic [127:0] aes_dout;
   logic         tx_start;
   logic [7:0]   tx_data;
   logic         tx_busy;

   modport master (
      input  buf_empty, buf_dout, aes_done, aes_dout, tx_busy,
      output buf_read_en, aes_din, aes_start, tx_start, tx_data
   );

   modport slave (
      output buf_empty, buf_dout, aes_done, aes_dout, tx_busy,
      input  buf_read_en, aes_din, aes_start, tx_start, tx_data
   );
endinterface

// File: rtl/aes_block_ctrl.sv
// Pops 128-bit blocks from the transmit buffer, runs them through the AES core and
// streams the result MSB byte first to the UART transmitter.
module aes_block_ctrl #(
   parameter int unsigned ENC_TIMEOUT = 1024,
   parameter int unsigned BLK_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   aes_block_ctrl_if.master     bus,
   output logic                 trigger,
   output logic                 busy,
   output logic                 timeout_err,
   output logic [BLK_CNT_W-1:0] blk_count
);

   localparam int unsigned TmoW = $clog2(ENC_TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StFetch, StStart, StEnc, StSend, StTxWait} state_e;

   state_e          state_q;
   logic [127:0]    din_q;
   logic [127:0]    shift_q;
   logic [3:0]      byte_idx_q;
   logic [TmoW-1:0] tmo_cnt_q;
   logic            txw_first_q;
   logic            aes_start_q;
   logic            tx_start_q;
   logic [7:0]      tx_data_q;
   logic            pop;

   // The buffer presents data the cycle after the pop, so the pop is issued from IDLE
   // itself and FETCH captures the word; gated by reset so it is 0 while in reset.
   assign pop = reset && (state_q == StIdle) && enable && !bus.buf_empty;

   assign bus.buf_read_en = pop;
   assign bus.aes_din     = din_q;
   assign bus.aes_start   = aes_start_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign busy            = (state_q != StIdle);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         din_q       <= '0;
         shift_q     <= '0;
         byte_idx_q  <= '0;
         tmo_cnt_q   <= '0;
         txw_first_q <= 1'b0;
         aes_start_q <= 1'b0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= '0;
         trigger     <= 1'b0;
         timeout_err <= 1'b0;
         blk_count   <= '0;
      end else begin
         aes_start_q <= 1'b0;
         tx_start_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pop) state_q <= StFetch;
            end
            StFetch: begin
               din_q       <= bus.buf_dout;
               aes_start_q <= 1'b1;
               trigger     <= 1'b1;
               state_q     <= StStart;
            end
            StStart: begin
               tmo_cnt_q <= '0;
               state_q   <= StEnc;
            end
            StEnc: begin
               if (bus.aes_done) begin
                  shift_q    <= bus.aes_dout;
                  byte_idx_q <= '0;
                  trigger    <= 1'b0;
                  state_q    <= StSend;
               end else if (tmo_cnt_q == TmoW'(ENC_TIMEOUT - 1)) begin
                  // Block is dropped; blk_count only counts fully transmitted blocks.
                  timeout_err <= 1'b1;
                  trigger     <= 1'b0;
                  state_q     <= StIdle;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
               end
            end
            StSend: begin
               if (!bus.tx_busy) begin
                  tx_start_q  <= 1'b1;
                  tx_data_q   <= shift_q[127:120];
                  txw_first_q <= 1'b1;
                  state_q     <= StTxWait;
               end
            end
            StTxWait: begin
               // First cycle ignores tx_busy so the UART has time to raise it.
               if (txw_first_q) begin
                  txw_first_q <= 1'b0;
               end else if (!bus.tx_busy) begin
                  shift_q    <= {shift_q[119:0], 8'h00};
                  byte_idx_q <= byte_idx_q + 4'd1;
                  if (byte_idx_q == 4'd15) begin
                     blk_count <= blk_count + BLK_CNT_W'(1);
                     state_q   <= StIdle;
                  end else begin
                     state_q <= StSend;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_block_ctrl.sv
// Directed bench for aes_block_ctrl with behavioural buffer, AES core and UART models.
module tb_aes_block_ctrl;
   localparam int unsigned EncTimeout = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        trigger;
   logic        busy;
   logic        timeout_err;
   logic [15:0] blk_count;

   aes_block_ctrl_if bus ();

   aes_block_ctrl #(
      .ENC_TIMEOUT(EncTimeout),
      .BLK_CNT_W  (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .bus        (bus),
      .trigger    (trigger),
      .busy       (busy),
      .timeout_err(timeout_err),
      .blk_count  (blk_count)
   );

   always #5 clk = ~clk;

   // Buffer model: data valid the cycle after the pop.
   logic [127:0] bq[$];
   logic         empty_m = 1'b1;
   logic [127:0] bdout_m = '0;
   int           pops = 0;
   assign bus.buf_empty = empty_m;
   assign bus.buf_dout  = bdout_m;
   always @(posedge clk) begin
      if (bus.buf_read_en) begin
         pops <= pops + 1;
         if (bq.size() != 0) bdout_m <= bq.pop_front();
      end
   end
   always @(negedge clk) empty_m <= (bq.size() == 0);

   // AES model: result = ~input, aes_done 10 cycles after aes_start; mode 1 never completes.
   int           aes_mode = 0;
   int           aes_cnt = 0;
   logic [127:0] aes_res = '0;
   logic         aes_done_m = 1'b0;
   logic [127:0] aes_dout_m = '0;
   assign bus.aes_done = aes_done_m;
   assign bus.aes_dout = aes_dout_m;
   always @(posedge clk) begin
      aes_done_m <= 1'b0;
      if (bus.aes_start && aes_mode == 0) begin
         aes_cnt <= 9;
         aes_res <= ~bus.aes_din;
      end else if (aes_cnt != 0) begin
         aes_cnt <= aes_cnt - 1;
         if (aes_cnt == 1) begin
            aes_done_m <= 1'b1;
            aes_dout_m <= aes_res;
         end
      end
   end

   // UART model: busy for 6 cycles after each accepted byte.
   logic [7:0] bytes[$];
   logic       tx_busy_m = 1'b0;
   int         ub_cnt = 0;
   int         overlap = 0;
   assign bus.tx_busy = tx_busy_m;
   always @(posedge clk) begin
      if (bus.tx_start) begin
         bytes.push_back(bus.tx_data);
         if (tx_busy_m) overlap <= overlap + 1;
         tx_busy_m <= 1'b1;
         ub_cnt    <= 6;
      end else if (ub_cnt != 0) begin
         ub_cnt <= ub_cnt - 1;
         if (ub_cnt == 1) tx_busy_m <= 1'b0;
      end
   end

   // Trigger window, timeout latency and inter-block idle monitors.
   int           cyc = 0;
   int           trig_len = 0;
   int           trig_bad = 0;
   int           start_cyc = 0;
   int           tmo_cyc = 0;
   logic         tmo_seen = 1'b0;
   logic         done_d = 1'b0;
   logic [127:0] din_at_start = '0;
   logic         b2b_mon = 1'b0;
   int           run = 0;
   int           max_run = 0;
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      done_d <= bus.aes_done;
      if (trigger) trig_len <= trig_len + 1;
      if ((bus.aes_start && !trigger) || (done_d && trigger)) trig_bad <= trig_bad + 1;
      if (bus.aes_start) begin
         din_at_start <= bus.aes_din;
         start_cyc    <= cyc;
      end
      if (timeout_err && !tmo_seen) begin
         tmo_seen <= 1'b1;
         tmo_cyc  <= cyc;
      end
      if (b2b_mon) begin
         if (!busy) begin
            run <= run + 1;
            if (run + 1 > max_run) max_run <= run + 1;
         end else begin
            run <= 0;
         end
      end
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_blk(input int target, input int limit);
      int n = 0;
      while (blk_count != 16'(target) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("wait_blk", blk_count, 128'(target));
   endtask

   task automatic check_bytes(input string tag, input int base, input logic [127:0] blk);
      logic [127:0] r;
      logic [7:0]   o;
      r = ~blk;
      for (int i = 0; i < 16; i++) begin
         o = 8'hxx;
         if (base + i < bytes.size()) o = bytes[base + i];
         check(tag, o, r[127 - 8*i -: 8]);
      end
   endtask

   task automatic push_blk(input logic [127:0] blk);
      bq.push_back(blk);
   endtask

   initial begin
      logic [127:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
      int n, p0, q0, t0;
      b0 = 128'h00112233445566778899AABBCCDDEEFF;
      b1 = 128'h0123456789ABCDEFFEDCBA9876543210;
      b2 = 128'hDEADBEEFCAFEF00D1234567890ABCDEF;
      b3 = 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0;
      b4 = 128'h11111111222222223333333344444444;
      b5 = 128'h55555555666666667777777788888888;
      b6 = 128'h99999999AAAAAAAABBBBBBBBCCCCCCCC;
      b7 = 128'hFEDCBA98765432100123456789ABCDEF;
      b8 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_trigger", trigger, 0);
      check("rst_blk_count", blk_count, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_outs", {bus.buf_read_en, bus.aes_start, bus.tx_start, bus.tx_data}, 0);
      check("rst_aes_din", bus.aes_din, 0);
      reset = 1'b1;

      // enable=0 with data available: no pop
      push_blk(b0);
      repeat (10) @(negedge clk);
      check("disabled_pops", pops, 0);
      check("disabled_busy", busy, 0);

      // Single block
      q0 = bytes.size();
      t0 = trig_len;
      enable = 1'b1;
      wait_blk(1, 1000);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("single_pops", pops, 1);
      check("single_din", din_at_start, b0);
      check("single_nbytes", bytes.size() - q0, 16);
      check("single_first", bytes[q0], 8'hFF);
      check("single_last", bytes[q0 + 15], 8'h00);
      check_bytes("single_byte", q0, b0);
      check("single_overlap", overlap, 0);
      check("trig_len", trig_len - t0, 11);
      check("trig_align", trig_bad, 0);

      // Back-to-back: three queued blocks
      push_blk(b1);
      push_blk(b2);
      push_blk(b3);
      repeat (2) @(negedge clk);
      p0 = pops;
      q0 = bytes.size();
      enable = 1'b1;
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      b2b_mon = 1'b1;
      wait_blk(4, 3000);
      b2b_mon = 1'b0;
      enable = 1'b0;
      check("b2b_pops", pops - p0, 3);
      check("b2b_nbytes", bytes.size() - q0, 48);
      check_bytes("b2b_blk1", q0, b1);
      check_bytes("b2b_blk2", q0 + 16, b2);
      check_bytes("b2b_blk3", q0 + 32, b3);
      check("b2b_gap", max_run <= 1, 1);
      check("b2b_overlap", overlap, 0);

      // Timeout: AES never completes
      aes_mode = 1;
      push_blk(b4);
      repeat (2) @(negedge clk);
      q0 = bytes.size();
      enable = 1'b1;
      n = 0;
      while (!timeout_err && n < 300) begin
         @(negedge clk);
         n++;
      end
      enable = 1'b0;
      repeat (2) @(negedge clk);
      check("tmo_err", timeout_err, 1);
      check("tmo_idle", busy, 0);
      check("tmo_trigger", trigger, 0);
      check("tmo_nbytes", bytes.size() - q0, 0);
      check("tmo_blk_count", blk_count, 4);
      check("tmo_latency", tmo_cyc - start_cyc, EncTimeout + 1);

      // Recovery with a working model; error stays sticky
      aes_mode = 0;
      push_blk(b5);
      repeat (2) @(negedge clk);
      q0 = bytes.size();
      enable = 1'b1;
      wait_blk(5, 1000);
      enable = 1'b0;
      check_bytes("recover_byte", q0, b5);
      check("tmo_sticky", timeout_err, 1);

      // enable dropped during ENC: block completes, next one is not started
      push_blk(b6);
      push_blk(b7);
      repeat (2) @(negedge clk);
      p0 = pops;
      q0 = bytes.size();
      enable = 1'b1;
      n = 0;
      while (!trigger && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("enc_reached", trigger, 1);
      @(negedge clk);
      enable = 1'b0;
      wait_blk(6, 1000);
      repeat (40) @(negedge clk);
      check("endrop_blk_count", blk_count, 6);
      check("endrop_pops", pops - p0, 1);
      check("endrop_nbytes", bytes.size() - q0, 16);
      check_bytes("endrop_byte", q0, b6);
      check("endrop_idle", busy, 0);

      // Empty buffer with enable=1
      bq.delete();
      repeat (2) @(negedge clk);
      p0 = pops;
      enable = 1'b1;
      repeat (10) @(negedge clk);
      check("empty_read_en", bus.buf_read_en, 0);
      check("empty_pops", pops - p0, 0);
      check("empty_busy", busy, 0);

      // Async reset mid-SEND after the fifth byte
      push_blk(b8);
      q0 = bytes.size();
      n = 0;
      while (bytes.size() < q0 + 5 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("pre_rst_nbytes", bytes.size() - q0, 5);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_trigger", trigger, 0);
      check("arst_blk_count", blk_count, 0);
      check("arst_timeout_err", timeout_err, 0);
      check("arst_outs", {bus.buf_read_en, bus.aes_start, bus.tx_start, bus.tx_data}, 0);
      check("arst_aes_din", bus.aes_din, 0);
      @(negedge clk);
      reset = 1'b1;
      p0 = pops;
      repeat (40) @(negedge clk);
      check("post_rst_nbytes", bytes.size() - q0, 5);
      check("post_rst_pops", pops - p0, 0);
      check("post_rst_blk_count", blk_count, 0);

      // New block after reset is processed normally
      push_blk(b1);
      repeat (2) @(negedge clk);
      q0 = bytes.size();
      wait_blk(1, 1000);
      check_bytes("post_rst_byte", q0, b1);
      check("final_overlap", overlap, 0);
      check("final_trig_align", trig_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_block_ctrl.md
Name: aes_block_ctrl

Overview:
- Sequencer between the 128-bit transmit buffer, the AES core and the UART transmitter.
- Pops one 128-bit block from the buffer and launches the AES core on it.
- On AES completion, serializes the 128-bit result into 16 bytes for the UART transmitter, MSB byte first.
- Drives a trigger strobe around the encryption window for side-channel capture, and counts processed blocks.

Parameters:
- ENC_TIMEOUT, 1024, max cycles to wait for aes_done after aes_start before aborting.
- BLK_CNT_W, 16, width of processed-block counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- enable  input  1  when 0, no new block is started; an in-flight block completes
- buf_empty  input  1  buffer has no readable 128-bit word
- buf_dout  input  128  buffer read data, valid the cycle after buf_read_en
- buf_read_en  output  1  one-cycle pop request to buffer
- aes_din  output  128  plaintext block held stable to AES core
- aes_start  output  1  one-cycle start pulse to AES core
- aes_done  input  1  one-cycle completion pulse from AES core
- aes_dout  input  128  AES result, valid in the aes_done cycle
- tx_start  output  1  one-cycle send request to UART transmitter
- tx_data  output  8  byte to transmit, stable from tx_start until next tx_start
- tx_busy  input  1  UART transmitter busy
- trigger  output  1  high from aes_start cycle through aes_done cycle inclusive
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  sticky, set on ENC timeout, cleared only by reset
- blk_count  output  BLK_CNT_W  number of blocks fully transmitted, wraps modulo 2^BLK_CNT_W

Behaviour:
- Reset (reset=0, async) values:
  - State IDLE.
  - All outputs 0, including aes_din, tx_data, blk_count and timeout_err.
  - Byte index 0, timeout counter 0.
- IDLE: if enable=1 and buf_empty=0, assert buf_read_en for exactly one cycle and go to FETCH. Otherwise stay.
- FETCH (1 cycle): latch buf_dout into aes_din, go to START.
- START (1 cycle): aes_start=1, trigger=1, clear timeout counter, go to ENC.
- ENC:
  - trigger=1; timeout counter increments each cycle.
  - On aes_done=1: latch aes_dout into a 128-bit shift register, byte index=0, go to SEND. trigger is still 1 in this cycle and 0 from the next.
  - If the counter reaches ENC_TIMEOUT with no aes_done: set timeout_err, drop trigger, go to IDLE. The block is discarded and blk_count is unchanged.
- SEND: when tx_busy=0, drive tx_data = shift[127:120] and tx_start=1 for one cycle, then go to TXWAIT.
- TXWAIT:
  - First cycle is unconditional, which allows the UART transmitter to raise tx_busy.
  - Then wait for tx_busy=0.
  - On release: shift register left by 8 and byte index +1.
  - If byte index was 15: blk_count +1, go to IDLE. Otherwise go to SEND.
- Minimum latency: buf_read_en to first tx_start is 4 cycles plus AES latency (IDLE→FETCH→START→ENC(done)→SEND).
- Only one pop per block. buf_read_en is never asserted outside IDLE.
- aes_done outside ENC is ignored.
- enable deassert mid-block does not abort; the check happens only in IDLE.
- Back-to-back blocks: a new pop may occur in the IDLE cycle immediately after the last byte completes.
- Reset mid-operation aborts immediately. The partially sent block is lost; no bytes resume after reset.

Test Plan:
- Single block:
  - Stimulus: buffer holds 0x00112233445566778899AABBCCDDEEFF; AES model returns input XOR all-ones after 10 cycles.
  - Required: exactly one buf_read_en pulse, and aes_din equals the block at aes_start.
  - Required: tx_data sequence 0xFF,0xEE,…,0x00, one tx_start per byte and no tx_start while tx_busy=1; blk_count=1.
- Trigger window:
  - Required: trigger rises in the aes_start cycle, falls the cycle after aes_done, and is high 11 cycles for the 10-cycle AES model.
- Back-to-back:
  - Stimulus: three blocks queued.
  - Required: 48 bytes in order, 3 pops, blk_count=3, busy low only between blocks for ≤1 cycle.
- Timeout:
  - Stimulus: AES model never asserts aes_done.
  - Required: after ENC_TIMEOUT cycles, timeout_err=1 (sticky), state IDLE, no tx_start, blk_count unchanged; next block with a working model still processes.
- enable/empty:
  - Stimulus: enable=0 with a non-empty buffer.
  - Required: no pop.
  - Stimulus: enable dropped during ENC.
  - Required: the block still transmits all 16 bytes, then the block stops.
  - Stimulus: buf_empty=1.
  - Required: idle with buf_read_en=0.
- Async reset mid-SEND:
  - Stimulus: pull reset low after byte 5, off-clock-edge.
  - Required: outputs 0 immediately; after release no tx_start until a new block is popped; blk_count=0.
